// File: rtl/load_bram_pkg.sv
// Shared types and constants for the pixel-FIFO to display-BRAM loader.
package load_bram_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BURST,
        DRAIN
    } state_t;

    localparam logic [3:0] WE_ALL  = 4'hF;
    localparam int         DATA_W  = 32;
    localparam int         ADDR_W  = 32;
    localparam int         COUNT_W = 11;

endpackage

// File: rtl/load_bram_addr_gen.sv
// Frame word-index counter with wrap and BRAM address formatting.
// Define LOAD_BRAM_BYTE_ADDR_EN for byte addressing (index << 2); default is word addressing.
module load_bram_addr_gen
    import load_bram_pkg::*;
#(
    parameter int FRAME_WORDS = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              advance,
    output logic [ADDR_W-1:0] addr,
    output logic              is_last
);

    localparam int IDX_W = $clog2(FRAME_WORDS);

    logic [IDX_W-1:0] idx_q;
    logic [IDX_W-1:0] idx_d;

    assign is_last = (idx_q == IDX_W'(FRAME_WORDS - 1));

    // Explicit wrap so frame sizes that are not a power of two still work
    always_comb begin
        idx_d = idx_q;
        if (advance) begin
            idx_d = is_last ? '0 : idx_q + IDX_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q <= '0;
        end else begin
            idx_q <= idx_d;
        end
    end

`ifdef LOAD_BRAM_BYTE_ADDR_EN
    assign addr = ADDR_W'({idx_q, 2'b00});
`else
    assign addr = ADDR_W'(idx_q);
`endif

endmodule

// File: rtl/load_bram_ctrl.sv
// Burst loader: drains the pixel FIFO into sequential BRAM port-A locations, one frame at a time.
// Address format selected by LOAD_BRAM_BYTE_ADDR_EN (see load_bram_addr_gen).
module load_bram_ctrl
    import load_bram_pkg::*;
#(
    parameter int BURST_LEN   = 16,
    parameter int FRAME_WORDS = 1024
) (
    input  logic               clk,
    input  logic               rst,
    output logic               ren_fifo,
    input  logic [DATA_W-1:0]  din_fifo,
    input  logic               empty_fifo,
    input  logic [COUNT_W-1:0] rd_data_count_fifo,
    output logic               wr_en_bram,
    output logic               wr_clk_bram,
    output logic [3:0]         we_bram,
    output logic [ADDR_W-1:0]  addr_bram,
    output logic [DATA_W-1:0]  din_bram,
    output logic               busy
);

    state_t             state_q, state_d;
    logic [COUNT_W-1:0] burst_cnt_q, burst_cnt_d;
    logic               drain_cnt_q, drain_cnt_d;
    logic               rd_valid_q, rd_valid_d;
    logic               frame_done_q, frame_done_d;
    logic               busy_q, busy_d;
    logic               wr_en_q, wr_en_d;
    logic [3:0]         we_q, we_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [DATA_W-1:0]  din_q, din_d;
    logic [ADDR_W-1:0]  gen_addr;
    logic               gen_last;

    assign wr_clk_bram = clk;
    assign ren_fifo    = (state_q == BURST) && !empty_fifo && !rst;

    load_bram_addr_gen #(
        .FRAME_WORDS(FRAME_WORDS)
    ) u_addr_gen (
        .clk    (clk),
        .rst    (rst),
        .advance(rd_valid_q),
        .addr   (gen_addr),
        .is_last(gen_last)
    );

    always_comb begin
        state_d     = state_q;
        burst_cnt_d = burst_cnt_q;
        drain_cnt_d = drain_cnt_q;
        busy_d      = busy_q;

        case (state_q)
            IDLE: begin
                if (rd_data_count_fifo >= COUNT_W'(BURST_LEN)) begin
                    state_d     = BURST;
                    burst_cnt_d = '0;
                    busy_d      = 1'b1;
                end
            end
            BURST: begin
                // Only real reads count, so an underflow stall stretches the burst
                if (ren_fifo) begin
                    if (burst_cnt_q == COUNT_W'(BURST_LEN - 1)) begin
                        state_d     = DRAIN;
                        drain_cnt_d = 1'b0;
                    end else begin
                        burst_cnt_d = burst_cnt_q + COUNT_W'(1);
                    end
                end
            end
            DRAIN: begin
                if (drain_cnt_q) begin
                    state_d = IDLE;
                end else begin
                    drain_cnt_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (frame_done_q) begin
            busy_d = 1'b0;
        end

        rd_valid_d   = ren_fifo;
        frame_done_d = rd_valid_q && gen_last;
        wr_en_d      = rd_valid_q;
        we_d         = rd_valid_q ? WE_ALL : 4'h0;
        addr_d       = addr_q;
        din_d        = din_q;
        if (rd_valid_q) begin
            addr_d = gen_addr;
            din_d  = din_fifo;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            burst_cnt_q  <= '0;
            drain_cnt_q  <= 1'b0;
            rd_valid_q   <= 1'b0;
            frame_done_q <= 1'b0;
            busy_q       <= 1'b0;
            wr_en_q      <= 1'b0;
            we_q         <= 4'h0;
            addr_q       <= '0;
            din_q        <= '0;
        end else begin
            state_q      <= state_d;
            burst_cnt_q  <= burst_cnt_d;
            drain_cnt_q  <= drain_cnt_d;
            rd_valid_q   <= rd_valid_d;
            frame_done_q <= frame_done_d;
            busy_q       <= busy_d;
            wr_en_q      <= wr_en_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            din_q        <= din_d;
        end
    end

    assign wr_en_bram = wr_en_q;
    assign we_bram    = we_q;
    assign addr_bram  = addr_q;
    assign din_bram   = din_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_load_bram_ctrl.sv
// Directed bench for load_bram_ctrl: FIFO model feeds sequential words, writes are logged and checked.
// Honours LOAD_BRAM_BYTE_ADDR_EN when computing expected addresses.
module tb_load_bram_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ren_fifo;
    logic [31:0] din_fifo = '0;
    logic        empty_fifo = 1'b1;
    logic [10:0] rd_data_count_fifo = '0;
    logic        wr_en_bram;
    logic        wr_clk_bram;
    logic [3:0]  we_bram;
    logic [31:0] addr_bram;
    logic [31:0] din_bram;
    logic        busy;

    int total = 0;
    int bad   = 0;

    logic [31:0] fifo_mem [0:2047];
    int          wr_ptr   = 0;
    int          rd_ptr   = 0;
    int          next_val = 1;

    logic [31:0] rec_addr [0:2047];
    logic [31:0] rec_data [0:2047];
    logic [3:0]  rec_we   [0:2047];
    int          rec_n = 0;
    int          ren_n = 0;

    always #5 clk = ~clk;

    load_bram_ctrl #(
        .BURST_LEN  (16),
        .FRAME_WORDS(1024)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .ren_fifo          (ren_fifo),
        .din_fifo          (din_fifo),
        .empty_fifo        (empty_fifo),
        .rd_data_count_fifo(rd_data_count_fifo),
        .wr_en_bram        (wr_en_bram),
        .wr_clk_bram       (wr_clk_bram),
        .we_bram           (we_bram),
        .addr_bram         (addr_bram),
        .din_bram          (din_bram),
        .busy              (busy)
    );

    // Standard FIFO: data appears the cycle after the read
    always @(posedge clk) begin
        if (ren_fifo) begin
            din_fifo <= fifo_mem[rd_ptr];
            rd_ptr   <= rd_ptr + 1;
        end
    end

    always @(negedge clk) begin
        if (ren_fifo) ren_n = ren_n + 1;
        if (wr_en_bram && rec_n < 2048) begin
            rec_addr[rec_n] = addr_bram;
            rec_data[rec_n] = din_bram;
            rec_we[rec_n]   = we_bram;
            rec_n = rec_n + 1;
        end
    end

    function automatic logic [31:0] exp_addr(input int idx);
`ifdef LOAD_BRAM_BYTE_ADDR_EN
        return 32'(idx) << 2;
`else
        return 32'(idx);
`endif
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("[TB] FAIL %s: got=%0h want=%0h", tag, got, want);
        end
    endtask

    task automatic applyStimulus(input logic [10:0] count, input logic empty);
        @(posedge clk);
        #1;
        rd_data_count_fifo = count;
        empty_fifo         = empty;
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    task automatic push_words(input int n);
        for (int i = 0; i < n; i++) begin
            fifo_mem[wr_ptr] = 32'(next_val);
            wr_ptr++;
            next_val++;
        end
    endtask

    task automatic start_burst();
        bit seen;
        seen = 1'b0;
        applyStimulus(11'd16, 1'b0);
        for (int i = 0; i < 10 && !seen; i++) begin
            settle();
            seen = ren_fifo;
        end
        checkOutput("burst_start", 32'(seen), 32'd1);
        applyStimulus(11'd0, 1'b0);
    endtask

    task automatic check_writes(input int base, input int idx0, input int val0, input int n);
        for (int i = 0; i < n; i++) begin
            checkOutput("wr_addr", rec_addr[base + i], exp_addr((idx0 + i) % 1024));
            checkOutput("wr_data", rec_data[base + i], 32'(val0 + i));
            checkOutput("wr_we", 32'(rec_we[base + i]), 32'hF);
        end
    endtask

    task automatic check_all_zero(input string tag);
        checkOutput({tag, "_ren"}, 32'(ren_fifo), 32'd0);
        checkOutput({tag, "_wr_en"}, 32'(wr_en_bram), 32'd0);
        checkOutput({tag, "_we"}, 32'(we_bram), 32'd0);
        checkOutput({tag, "_addr"}, addr_bram, 32'd0);
        checkOutput({tag, "_din"}, din_bram, 32'd0);
        checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int  base;
        int  rbase;
        bit  found;

        $display("[TB] start");
        repeat (3) @(posedge clk);
        settle();
        check_all_zero("reset");
        checkOutput("wr_clk_follows_clk", 32'(wr_clk_bram), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (5) settle();
        checkOutput("idle_empty_no_read", 32'(ren_n), 32'd0);

        // Threshold: 15 must not start, 16 must
        push_words(16);
        applyStimulus(11'd15, 1'b0);
        repeat (8) settle();
        checkOutput("below_threshold", 32'(ren_n), 32'd0);
        base  = rec_n;
        rbase = ren_n;
        start_burst();
        checkOutput("busy_on_start", 32'(busy), 32'd1);
        repeat (2) settle();
        checkOutput("first_wr_en", 32'(wr_en_bram), 32'd1);
        checkOutput("first_addr", addr_bram, exp_addr(0));
        checkOutput("first_din", din_bram, 32'd1);
        repeat (22) settle();
        checkOutput("burst_reads", 32'(ren_n - rbase), 32'd16);
        checkOutput("burst_writes", 32'(rec_n - base), 32'd16);
        check_writes(base, 0, 1, 16);
        checkOutput("busy_mid_frame", 32'(busy), 32'd1);
        checkOutput("din_holds", din_bram, 32'd16);

        // Fill the rest of the frame and watch the wrap
        for (int b = 1; b < 63; b++) begin
            push_words(16);
            start_burst();
            repeat (22) settle();
        end
        push_words(16);
        start_burst();
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            settle();
            if (wr_en_bram && addr_bram == exp_addr(1023)) found = 1'b1;
        end
        checkOutput("last_write_seen", 32'(found), 32'd1);
        checkOutput("busy_at_last_write", 32'(busy), 32'd1);
        settle();
        checkOutput("busy_after_frame", 32'(busy), 32'd0);
        repeat (5) settle();
        checkOutput("frame_writes", 32'(rec_n - base), 32'd1024);
        check_writes(base, 0, 1, 1024);

        base = rec_n;
        push_words(16);
        start_burst();
        repeat (22) settle();
        check_writes(base, 0, 1025, 16);
        checkOutput("busy_new_frame", 32'(busy), 32'd1);

        // Underflow: empty for 3 cycles after 3 reads
        base  = rec_n;
        rbase = ren_n;
        push_words(16);
        start_burst();
        applyStimulus(11'd0, 1'b0);
        applyStimulus(11'd0, 1'b1);
        settle();
        checkOutput("stall_no_read", 32'(ren_fifo), 32'd0);
        applyStimulus(11'd0, 1'b1);
        applyStimulus(11'd0, 1'b1);
        applyStimulus(11'd0, 1'b0);
        repeat (25) settle();
        checkOutput("underflow_reads", 32'(ren_n - rbase), 32'd16);
        checkOutput("underflow_writes", 32'(rec_n - base), 32'd16);
        check_writes(base, 16, 1041, 16);

        // Reset after 5 reads: only the 4 words already in the pipe land
        base  = rec_n;
        rbase = ren_n;
        push_words(16);
        start_burst();
        applyStimulus(11'd0, 1'b0);
        applyStimulus(11'd0, 1'b0);
        applyStimulus(11'd0, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        settle();
        @(posedge clk);
        #1;
        settle();
        check_all_zero("midburst_reset");
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (10) settle();
        checkOutput("reset_reads", 32'(ren_n - rbase), 32'd5);
        checkOutput("reset_writes", 32'(rec_n - base), 32'd4);
        check_writes(base, 32, 1057, 4);

        base = rec_n;
        push_words(5);
        start_burst();
        repeat (22) settle();
        checkOutput("post_reset_writes", 32'(rec_n - base), 32'd16);
        check_writes(base, 0, 1062, 16);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/load_bram_ctrl.md
# load_bram_ctrl

Streaming loader that drains 32-bit pixel/disparity words from the `px_in_fifo` read port and writes them to sequential locations in port A of the dual-port `bram`. It sits between the pixel input FIFO and the display-map BRAM. It reads in fixed-length bursts gated by the FIFO fill level, fills one frame of `FRAME_WORDS` words, then wraps to address 0 for the next frame.

## Interface
- `BURST_LEN`, 16: words read per burst; power of two, at most 1024.
- `FRAME_WORDS`, 1024: words per frame; integer multiple of `BURST_LEN`.
- `clk` in 1: clock for the loader, FIFO read side and BRAM port A.
- `rst` in 1: reset, synchronous, active-high; clock `clk`.
- `ren_fifo` out 1: FIFO read enable. Standard (non-FWFT) FIFO: data appears on `din_fifo` one cycle after the read.
- `din_fifo` in 32: FIFO read data.
- `empty_fifo` in 1: FIFO empty flag.
- `rd_data_count_fifo` in 11: FIFO read-side occupancy.
- `wr_en_bram` out 1: BRAM port-A enable (`ena`).
- `wr_clk_bram` out 1: BRAM write clock. Continuous assign of `clk`.
- `we_bram` out 4: byte write enables. `4'hF` when writing, else `4'h0`.
- `addr_bram` out 32: BRAM address.
- `din_bram` out 32: BRAM write data.
- `busy` out 1: high while a frame is being loaded.

## Operation
- States: IDLE, BURST, DRAIN.
- **IDLE**
  - `ren_fifo` = 0.
  - Go to BURST when `rd_data_count_fifo >= BURST_LEN`.
  - On the IDLE→BURST transition, set `busy` to 1.
- **BURST**
  - `ren_fifo` = 1 for exactly `BURST_LEN` consecutive cycles, counted by the burst counter.
  - Also gated: `ren_fifo = state==BURST && !empty_fifo`. The counter advances only on an actual read.
  - After the last read, go to DRAIN.
- **DRAIN**
  - Wait until all in-flight words are written (2 cycles), then go to IDLE.
- **Write pipeline**
  - `rd_valid` <= `ren_fifo`.
  - When `rd_valid`: register `din_bram <= din_fifo`, `wr_en_bram <= 1`, `we_bram <= 4'hF`, and drive `addr_bram` from the word index.
  - After each write, the word index increments.
- **End of frame**
  - The word index is 0..`FRAME_WORDS`-1. After the write at index `FRAME_WORDS`-1, the index wraps to 0.
  - `busy` drops the cycle after that write.
- `din_bram` holds its last value when not writing.

## Timing
- **Reset values:** `ren_fifo` 0, `wr_en_bram` 0, `we_bram` 0, `addr_bram` 0, `din_bram` 0, `busy` 0. State IDLE, index 0.
- **Read-to-write latency:** `ren_fifo` at cycle t → `din_fifo` valid at t+1 → `wr_en_bram`/`we_bram`/`din_bram`/`addr_bram` valid at t+2. Throughput is 1 word/cycle inside a burst.
- **Burst start:** BURST starts the cycle after the threshold is met in IDLE. Minimum gap between bursts is 3 cycles (DRAIN 2 + IDLE 1).
- **Empty during BURST:** `empty_fifo` asserted in BURST (underflow despite the count) stalls reads. Writes are never issued for unread words.
- **Reset mid-burst:** aborts; in-flight words are discarded and not written. The index returns to 0.
- **Count at threshold:** a count exactly equal to `BURST_LEN` starts a burst.

## Configuration
- `LOAD_BRAM_BYTE_ADDR_EN`
  - Defined: `addr_bram = index << 2` (byte addressing, Xilinx 32-bit BRAM interface).
  - Undefined: `addr_bram = index` (word addressing).
  - Upper address bits are zero in both cases.

## Structure
- **Shared package `load_bram_pkg`:**
  - state enum (IDLE/BURST/DRAIN)
  - `WE_ALL = 4'hF`
  - data width 32
  - count width 11
- **Sub-module `load_bram_addr_gen`:** frame word-index counter with wrap and byte/word address formatting.

## Test plan
- **Reset:** hold `rst` 3 cycles → all outputs 0. After release with FIFO empty, `ren_fifo` stays 0.
- **Threshold:** `rd_data_count_fifo`=15 → no read. Raise to 16 → `ren_fifo` high 16 cycles, then the first write `addr_bram`=0, `din_bram`=first FIFO word, 2 cycles after the first read.
- **Sequential data:** FIFO loaded with 1,2,3… → BRAM[i] = i+1 for i=0..15, `we_bram`=F on each write. Byte mode gives addresses 0,4,…,60.
- **Frame wrap:** 64 bursts → `busy` falls after index 1023. The next burst writes address 0 again.
- **Underflow:** `empty_fifo` forced high for 3 cycles mid-burst → reads pause, no gaps or duplicates in the addresses, and 16 writes total.
- **Reset mid-burst:** reset after 5 reads → no further writes. The next burst starts at address 0.
